alien_shot_controller: RTL

Downstream consumer of the alien formation: samples the formation's per-alien armed flags and positions, chooses a firing alien once per fire interval, and owns a small pool of falling alien shots. Provides shot positions to the renderer and the player-collision logic, and takes kill requests back from that logic. Runs on the pixel clock and advances shots once per video frame.

---
 rtl/alien_shot_controller_if.sv | 31 +++
 rtl/alien_shot_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alien_shot_controller_if.sv
// Bus between the alien formation / collision logic and the shot controller.
// The master side drives frame timing, formation state and kill requests;
// the slave side (the controller) returns the shot pool state.
interface alien_shot_controller_if #(
  parameter int NUM_ROWS  = 3,
  parameter int NUM_COLS  = 5,
  parameter int MAX_SHOTS = 4
);
  logic                                    frame_tick;
  logic                                    clear_shots;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]       armed_matrix;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][15:0] alien_positions_x;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][15:0] alien_positions_y;
  logic [MAX_SHOTS-1:0]                    shot_kill;
  logic [MAX_SHOTS-1:0]                    shot_active;
  logic [MAX_SHOTS-1:0][15:0]              shot_x;
  logic [MAX_SHOTS-1:0][15:0]              shot_y;
  logic                                    fire_pulse;

  modport master (
    output frame_tick, clear_shots, armed_matrix,
           alien_positions_x, alien_positions_y, shot_kill,
    input  shot_active, shot_x, shot_y, fire_pulse
  );

  modport slave (
    input  frame_tick, clear_shots, armed_matrix,
           alien_positions_x, alien_positions_y, shot_kill,
    output shot_active, shot_x, shot_y, fire_pulse
  );
endinterface

// File: rtl/alien_shot_controller.sv
// Alien shot controller: picks a firing alien once per fire interval and
// owns a small pool of falling shots that advance once per frame.
//
// Optional feature: define ALIEN_SHOT_LFSR_EN to choose the scan start
// column from a free-running 16-bit Galois LFSR instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a frame tick with cooldown expired and a free slot
// SCAN  | testing one formation column per cycle for an armed alien
// SPAWN | shot just written to its slot, fire_pulse high; back to IDLE
//
// The column that SCAN finds is written into its slot on the edge that
// leaves SCAN, so the new shot and fire_pulse are visible while the FSM
// sits in SPAWN (frame tick at t -> visible at t+2+k, k columns skipped).
module alien_shot_controller #(
  parameter int NUM_ROWS      = 3,
  parameter int NUM_COLS      = 5,
  parameter int MAX_SHOTS     = 4,
  parameter int FIRE_INTERVAL = 60,
  parameter int SHOT_SPEED    = 2,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 16,
  parameter int SCREEN_BOTTOM = 480
) (
  input logic                   clk,
  input logic                   rst,
  alien_shot_controller_if.slave bus
);

  localparam int CD_W  = $clog2(FIRE_INTERVAL) + 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(NUM_COLS) + 1;

  localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(FIRE_INTERVAL - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_COLS - 1);
  localparam logic [16:0]      SPEED_17  = 17'(SHOT_SPEED);
  localparam logic [16:0]      BOTTOM_17 = 17'(SCREEN_BOTTOM);
  localparam logic [15:0]      X_OFFSET  = 16'(SPRITE_W / 2);
  localparam logic [15:0]      Y_OFFSET  = 16'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CD_W-1:0]            cooldown;
  logic [COL_W-1:0]           scan_col;
  logic [CNT_W-1:0]           scan_cnt;
  logic [COL_W-1:0]           last_col;
  logic [COL_W-1:0]           start_col;

  logic [MAX_SHOTS-1:0]       active;
  logic [MAX_SHOTS-1:0][15:0] pos_x;
  logic [MAX_SHOTS-1:0][15:0] pos_y;
  logic                       fire;

  logic                       col_armed;
  logic [ROW_W-1:0]           col_row;
  logic [15:0]                spawn_x;
  logic [15:0]                spawn_y;
  logic [MAX_SHOTS-1:0]       free_slots;
  logic [MAX_SHOTS-1:0]       spawn_mask;
  logic [MAX_SHOTS-1:0]       kill_eff;
  logic                       spawn_now;
  logic                       scan_begin;

  // Start column for the next scan.
`ifdef ALIEN_SHOT_LFSR_EN
  localparam logic [7:0] NUM_COLS_8 = 8'(NUM_COLS);
  logic [15:0] lfsr;

  // Galois LFSR stepping every cycle, taps 0xB400.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign start_col = COL_W'(lfsr[7:0] % NUM_COLS_8);
`else
  assign start_col = (last_col == COL_LAST) ? '0 : last_col + COL_W'(1);
`endif

  // Armed lookup for the column under scan; lowest armed row wins.
  always_comb begin
    col_armed = 1'b0;
    col_row   = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (bus.armed_matrix[r][scan_col]) begin
        col_armed = 1'b1;
        col_row   = ROW_W'(r);
      end
    end
    spawn_x = bus.alien_positions_x[col_row][scan_col] + X_OFFSET;
    spawn_y = bus.alien_positions_y[col_row][scan_col] + Y_OFFSET;
  end

  // Slot allocation: lowest-index free slot as a one-hot mask.
  always_comb begin
    free_slots = ~active;
    kill_eff   = bus.shot_kill & active;
    spawn_now  = (state == SCAN) && col_armed && (|free_slots) && !bus.clear_shots;
    spawn_mask = spawn_now ? (free_slots & (~free_slots + MAX_SHOTS'(1))) : '0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt  = state;
    scan_begin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_tick && (cooldown == '0) && !(&active)) begin
          state_nxt  = SCAN;
          scan_begin = 1'b1;
        end
      end
      SCAN: begin
        if (col_armed) begin
          state_nxt = SPAWN;
        end else if (scan_cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      SPAWN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (bus.clear_shots) begin
      state_nxt  = IDLE;
      scan_begin = 1'b0;
    end
  end

  // Column walker: load start column on scan entry, advance on empty columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_col <= '0;
      scan_cnt <= '0;
    end else if (scan_begin) begin
      scan_col <= start_col;
      scan_cnt <= '0;
    end else if ((state == SCAN) && !col_armed) begin
      scan_col <= (scan_col == COL_LAST) ? '0 : scan_col + COL_W'(1);
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Fire cooldown: reloaded by a spawn or a clear, counts down on frame ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cooldown <= CD_RELOAD;
    end else if (bus.clear_shots || spawn_now) begin
      cooldown <= CD_RELOAD;
    end else if (bus.frame_tick && (cooldown != '0)) begin
      cooldown <= cooldown - CD_W'(1);
    end
  end

  // Remember the column that last fired, for round-robin start.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_col <= COL_LAST;
    end else if (spawn_now) begin
      last_col <= scan_col;
    end
  end

  // Shot pool: clear, kill, spawn, then motion, in that priority per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      pos_x  <= '0;
      pos_y  <= '0;
    end else begin
      for (int i = 0; i < MAX_SHOTS; i++) begin
        logic [16:0] y_next;
        y_next = {1'b0, pos_y[i]} + SPEED_17;
        if (bus.clear_shots) begin
          active[i] <= 1'b0;
        end else if (kill_eff[i]) begin
          active[i] <= 1'b0;
        end else if (spawn_mask[i]) begin
          active[i] <= 1'b1;
          pos_x[i]  <= spawn_x;
          pos_y[i]  <= spawn_y;
        end else if (bus.frame_tick && active[i]) begin
          pos_y[i] <= y_next[15:0];
          if (y_next[16] || (y_next >= BOTTOM_17)) begin
            active[i] <= 1'b0;
          end
        end
      end
    end
  end

  // One-cycle fire strobe, coincident with the new shot becoming visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire <= 1'b0;
    end else begin
      fire <= spawn_now;
    end
  end

  assign bus.shot_active = active;
  assign bus.shot_x      = pos_x;
  assign bus.shot_y      = pos_y;
  assign bus.fire_pulse  = fire;

endmodule
